// File: rtl/lsu_wb_bridge_if.sv
// rtl/lsu_wb_bridge_if.sv - load/store request and wishbone command/response signal bundle
interface lsu_wb_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        cmd_busy;
  logic        rsp_stb;
  logic [33:0] rsp_word;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  cmd_busy, rsp_stb, rsp_word,
    output req_ready, done, rdata, err, cmd_stb, cmd_word
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output cmd_busy, rsp_stb, rsp_word,
    input  req_ready, done, rdata, err, cmd_stb, cmd_word
  );
endinterface

// File: rtl/lsu_wb_bridge.sv
// rtl/lsu_wb_bridge.sv - RV32I load/store to wishbone command/response bridge
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_wb_bridge #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset,
  lsu_wb_bridge_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETADR = 3'd1;
  localparam logic [2:0] READ   = 3'd2;
  localparam logic [2:0] RWAIT  = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] WWAIT  = 3'd5;
  localparam logic [2:0] RESP   = 3'd6;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              cache_vld;
  logic [ADDR_W-1:0] cache_tag;
  logic [15:0]       cnt;

  logic [ADDR_W-1:0] req_word;
  logic              illegal;
  logic              hit;
  logic              req_sw;
  logic              store_word;
  logic              stb;
  logic              advance;
  logic              timed_out;
  logic [29:0]       adr_ext;
  logic [33:0]       word_out;
  logic              unused_ok;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'h0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic is_byte, input logic [1:0] lo);
    merge = w;
    if (is_byte) merge[{lo, 3'b000} +: 8] = d[7:0];
    else         merge[{lo[1], 4'b0000} +: 16] = d[15:0];
  endfunction

  always_comb begin
    req_word = bus.req_addr[ADDR_W+1:2];
    hit      = cache_vld && (cache_tag == req_word);
    req_sw   = bus.req_we && (bus.req_funct3 == 3'b010);
    illegal  = bus.req_we ? (bus.req_funct3[2] || (bus.req_funct3 == 3'b011))
                          : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])    illegal = 1'b1;
    if ((bus.req_funct3[1:0] == 2'b10) && |bus.req_addr[1:0]) illegal = 1'b1;
`endif
  end

  always_comb begin
    store_word = we_q && (f3_q == 3'b010);
    stb        = (state == SETADR) || (state == READ) || (state == WRITE);
    advance    = ((state == RWAIT) || (state == WWAIT)) ? bus.rsp_stb : (stb && !bus.cmd_busy);
    timed_out  = (cnt == TO_LAST);
    adr_ext    = '0;
    adr_ext[ADDR_W-1:0] = word_q;
    case (state)
      SETADR:  word_out = {2'b10, 1'b0, 1'b1, adr_ext};
      READ:    word_out = {2'b00, 32'h0};
      WRITE:   word_out = {2'b01, wdata_q};
      default: word_out = '0;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.done      = (state == RESP);
  assign bus.rdata     = (state == RESP) ? rdata_q : 32'h0;
  assign bus.err       = (state == RESP) && err_q;
  assign bus.cmd_stb   = stb;
  assign bus.cmd_word  = word_out;
  assign unused_ok     = &{1'b0, bus.rsp_word[33:32], bus.req_addr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b0;
      lo_q      <= 2'b0;
      word_q    <= '0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      cache_vld <= 1'b0;
      cache_tag <= '0;
      cnt       <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            lo_q    <= bus.req_addr[1:0];
            word_q  <= req_word;
            wdata_q <= bus.req_wdata;
            rdata_q <= 32'h0;
            err_q   <= illegal;
            cnt     <= 16'h0;
            if (illegal)  state <= RESP;
            else if (hit) state <= req_sw ? WRITE : READ;
            else          state <= SETADR;
          end
        end
        SETADR, READ, RWAIT, WRITE, WWAIT: begin
          if (advance) begin
            cnt <= 16'h0;
            case (state)
              SETADR: begin
                cache_vld <= 1'b1;
                cache_tag <= word_q;
                state     <= store_word ? WRITE : READ;
              end
              READ:  state <= RWAIT;
              RWAIT: begin
                // Sub-word stores reuse the fetched word as the merge base.
                if (we_q) begin
                  wdata_q <= merge(bus.rsp_word[31:0], wdata_q, (f3_q[1:0] == 2'b00), lo_q);
                  state   <= WRITE;
                end else begin
                  rdata_q <= load_ext(bus.rsp_word[31:0], f3_q, lo_q);
                  state   <= RESP;
                end
              end
              WRITE:   state <= WWAIT;
              default: state <= RESP;
            endcase
          end else if (timed_out) begin
            // The master may have lost track of the address, so force a fresh set-address.
            state     <= RESP;
            err_q     <= 1'b1;
            rdata_q   <= 32'h0;
            cache_vld <= 1'b0;
          end else begin
            cnt <= cnt + 16'h1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_wb_bridge.md
LSU_WB_BRIDGE -- requirements
Module: lsu_wb_bridge

Interface
REQ-001 Parameter ADDR_W, default 30: word-address width carried in set-address commands, range 1..30.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles waited in any bus state before aborting, range 1..65535.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  load/store request present.
REQ-006 req_ready  out  1  bridge idle and able to accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32I size and sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  load result, extended; valid while done=1.
REQ-013 err  out  1  abort or illegal request; valid while done=1.
REQ-014 cmd_stb, cmd_word[33:0]  out  wishbone-master command strobe and word.
REQ-015 cmd_busy, rsp_stb, rsp_word[33:0]  in  master busy flag, response strobe and response word (data in [31:0]).

Function
REQ-016 Command encoding SHALL be: read {2'b00, 32'h0}; write {2'b01, data}; set-address {2'b10, 1'b0, 1'b1, zero-extended word address [ADDR_W+1:2]}.
REQ-017 A command SHALL transfer on a rising edge where cmd_stb=1 and cmd_busy=0; cmd_stb and cmd_word SHALL be held stable until then.
REQ-018 States SHALL be IDLE, SETADR, READ, RWAIT, WRITE, WWAIT, RESP.
REQ-019 req_ready SHALL equal (state==IDLE); a request is accepted when req_valid and req_ready are both 1, capturing all req_* inputs.
REQ-020 On accept: illegal funct3 (load 011/110/111, store 011-111) -> RESP with err=1 and no bus traffic.
REQ-021 On accept: the next state is SETADR unless the address cache is valid and equal to req_addr[ADDR_W+1:2]; on a cache hit, SW goes to WRITE and all other requests go to READ.
REQ-022 SETADR -> transfer -> the cache is loaded and marked valid; then WRITE for SW, otherwise READ.
REQ-023 READ -> transfer -> RWAIT; RWAIT -> rsp_stb -> rsp_word[31:0] captured; loads go to RESP, SB/SH go to WRITE.
REQ-024 SB/SH SHALL read-modify-write: the captured word has lane addr[1:0] (SB) or half addr[1] (SH) replaced by req_wdata[7:0]/[15:0].
REQ-025 WRITE -> transfer -> WWAIT; WWAIT -> rsp_stb -> RESP.
REQ-026 Loads SHALL select byte lane addr[1:0] or half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
REQ-027 RESP SHALL assert done for exactly one cycle, then return to IDLE; rdata and err SHALL be 0 whenever done=0.
REQ-028 A timeout counter SHALL clear on entry to each bus state; when it reaches TIMEOUT -> RESP with err=1 and the cache invalidated.
REQ-029 rsp_stb outside RWAIT/WWAIT SHALL be ignored.
REQ-030 Minimum LW latency with a cache hit and zero-wait master SHALL be accept + 3 cycles to the done pulse.

Reset
REQ-031 reset low SHALL immediately force IDLE, invalidate the cache, clear the counter and drive cmd_stb=0, cmd_word=0, done=0, err=0, rdata=0, req_ready=1.
REQ-032 Reset mid-transaction SHALL abandon it with no done pulse; responses still arriving after reset is released SHALL be ignored per REQ-029.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, -> RESP with err=1 and no bus traffic.
REQ-034 LSU_MISALIGN_TRAP_EN undefined: such addresses SHALL be aligned down (low bits ignored) and the access completes normally.

Verification
REQ-035 Cold LW addr 0x100, master returns 0xDEADBEEF -> set-address word {2'b10,1'b0,1'b1,30'h40}, then read; done with rdata=0xDEADBEEF, err=0.
REQ-036 Repeat LB addr 0x103 on the same word -> no set-address issued; rdata=0xFFFFFFDE.
REQ-037 SB addr 0x101, wdata 0x55, memory word 0x11223344 -> read then write {2'b01,32'h11225544}; done, err=0.
REQ-038 cmd_busy held 1 for 5 cycles during READ -> cmd_stb/cmd_word stable for all 5 cycles; transfer on the first busy=0 edge.
REQ-039 TIMEOUT=4, no rsp_stb -> done with err=1 exactly 4 cycles after RWAIT entry; next access to the same word reissues set-address.
REQ-040 LSU_MISALIGN_TRAP_EN defined, LW addr 0x102 -> done with err=1, cmd_stb never asserted; reset pulsed during RWAIT -> outputs zero and req_ready=1 immediately.
